// File: rtl/spram_fifo_vr.sv
// spram_fifo_vr: valid/ready FIFO built around a single-port RAM.
// A one-entry hold register decouples the write handshake from RAM write
// slots; a two-entry output buffer (obuf) hides the RAM read latency.
// A two-state arbiter shares the single RAM port between hold draining and
// obuf refilling, alternating whenever both contend.
// Optional feature macro: SPRAM_FIFO_BYPASS_EN -- when the FIFO is otherwise
// drained, an accepted beat skips the RAM and lands directly in obuf.
module spram_fifo_vr #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1),
  parameter int AF_THRESH  = FIFO_DEPTH - 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full
);

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] AF_C    = CNT_WIDTH'(AF_THRESH);

  typedef enum logic {
    ARB_WR_PRI = 1'b0,
    ARB_RD_PRI = 1'b1
  } arb_state_e;

  arb_state_e            arb_state_q;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_WIDTH-1:0]  ram_cnt_q;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic                  hold_vld_q;
  logic [DATA_WIDTH-1:0] hold_q;

  logic [DATA_WIDTH-1:0] obuf_q [2];
  logic [DATA_WIDTH-1:0] obuf_d [2];
  logic [1:0]            obuf_cnt_q, obuf_cnt_d;
  logic [1:0]            obuf_eff;

  logic                  accept, deliver;
  logic                  wr_req, rd_req, wr_grant, rd_grant;
  logic                  bypass, to_hold, obuf_push;
  logic [DATA_WIDTH-1:0] push_data;

  // Handshakes and flags, all derived from registered state.
  assign m_valid     = (obuf_cnt_q != 2'd0);
  assign m_data      = obuf_q[0];
  assign deliver     = m_valid && m_ready;
  assign s_ready     = (count_q < DEPTH_C) && (!hold_vld_q || wr_grant);
  assign accept      = s_valid && s_ready;
  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign almost_full = (count_q >= AF_C);

  // An entry leaving obuf this cycle already counts as a free slot.
  assign obuf_eff = obuf_cnt_q - {1'b0, deliver};

  assign wr_req = hold_vld_q;
  assign rd_req = (ram_cnt_q != '0) && (obuf_eff < 2'd2);

  // Grant the lone requester, or the priority side when both contend.
  assign wr_grant = wr_req && (!rd_req || (arb_state_q == ARB_WR_PRI));
  assign rd_grant = rd_req && (!wr_req || (arb_state_q == ARB_RD_PRI));

`ifdef SPRAM_FIFO_BYPASS_EN
  // Hold and RAM empty means obuf holds every older beat, so order is kept.
  assign bypass = accept && !hold_vld_q && (ram_cnt_q == '0) && (obuf_eff < 2'd2);
`else
  assign bypass = 1'b0;
`endif

  assign to_hold   = accept && !bypass;
  assign obuf_push = rd_grant || bypass;
  // The RAM read word is captured by obuf, so obuf is the RAM output register.
  assign push_data = rd_grant ? mem[rd_ptr_q] : s_data;

  // Next obuf contents: pop the head on delivery, append behind the survivors.
  always_comb begin
    obuf_d     = obuf_q;
    obuf_cnt_d = obuf_eff;
    if (deliver) begin
      obuf_d[0] = obuf_q[1];
    end
    if (obuf_push) begin
      obuf_d[obuf_eff[0]] = push_data;
      obuf_cnt_d          = obuf_eff + 2'd1;
    end
  end

  // Occupancy counter: entries accepted and not yet delivered.
  always_comb begin
    count_d = count_q + CNT_WIDTH'(accept) - CNT_WIDTH'(deliver);
  end

  // Arbiter: flip priority only after a contended grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_state_q <= ARB_WR_PRI;
    end else if (wr_req && rd_req) begin
      arb_state_q <= (arb_state_q == ARB_WR_PRI) ? ARB_RD_PRI : ARB_WR_PRI;
    end
  end

  // Single-port RAM write; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_grant) begin
      mem[wr_ptr_q] <= hold_q;
    end
  end

  // Hold register, RAM pointers and RAM occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
    end else begin
      if (to_hold) begin
        hold_vld_q <= 1'b1;
        hold_q     <= s_data;
      end else if (wr_grant) begin
        hold_vld_q <= 1'b0;
      end
      if (wr_grant) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_grant) rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
      ram_cnt_q <= ram_cnt_q + CNT_WIDTH'(wr_grant) - CNT_WIDTH'(rd_grant);
    end
  end

  // Output buffer and total occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obuf_q[0]  <= '0;
      obuf_q[1]  <= '0;
      obuf_cnt_q <= 2'd0;
      count_q    <= '0;
    end else begin
      obuf_q     <= obuf_d;
      obuf_cnt_q <= obuf_cnt_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_spram_fifo_vr.sv
// Bench for spram_fifo_vr: a queue/counter reference model checked every
// cycle on the falling edge, plus directed phases with literal expectations.
module tb_spram_fifo_vr;

  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int AF    = DEPTH - 4;
`ifdef SPRAM_FIFO_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 3;
`endif

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [5:0]    count;
  logic          empty;
  logic          full;
  logic          almost_full;

  spram_fifo_vr dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [DW-1:0] exp_q [$];
  int            mcnt     = 0;
  int            acc_cnt  = 0;
  int            dlv_cnt  = 0;
  bit            chk_en   = 1'b0;
  bit            hold_prev = 1'b0;
  logic [DW-1:0] prev_data;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic timeout(input string nm);
    chk_cnt++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: order via queue, occupancy via accept/deliver arithmetic.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else if (chk_en) begin
      check("count", 32'(count), 32'(mcnt));
      check("empty", 32'(empty), 32'(mcnt == 0));
      check("full", 32'(full), 32'(mcnt == DEPTH));
      check("almost_full", 32'(almost_full), 32'(mcnt >= AF));
      if (mcnt == DEPTH) check("s_ready_at_full", 32'(s_ready), 32'd0);
      if (mcnt == 0) begin
        check("m_valid_when_empty", 32'(m_valid), 32'd0);
        check("s_ready_when_empty", 32'(s_ready), 32'd1);
      end
      if (m_valid) begin
        if (exp_q.size() == 0) check("m_valid_no_data", 32'(m_valid), 32'd0);
        else check("m_data_order", 32'(m_data), 32'(exp_q[0]));
      end
      if (hold_prev) begin
        check("m_valid_held", 32'(m_valid), 32'd1);
        check("m_data_stable", 32'(m_data), 32'(prev_data));
      end
      if (s_valid && s_ready) begin
        exp_q.push_back(s_data);
        mcnt++;
        acc_cnt++;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        mcnt--;
        dlv_cnt++;
      end
      hold_prev = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  // Offer one beat until accepted; s_ready is sampled mid-cycle.
  task automatic push(input logic [DW-1:0] d, output bit ok);
    s_valid = 1'b1;
    s_data  = d;
    ok      = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      #2;
      ok = s_ready;
      next_cyc();
    end
    if (!ok) timeout("push");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_almost_full"}, 32'(almost_full), 32'd0);
    check({tag, "_m_data"}, 32'(m_data), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int first;
    int got;
    int nxt;
    int acc_win;
    int d0;

    // Reset with s_valid driven.
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hAA;
    m_ready = 1'b0;
    repeat (3) next_cyc();
    check_reset_outputs("rst");
    rst_n   = 1'b1;
    s_valid = 1'b0;
    chk_en  = 1'b1;
    #2;
    check("rst_s_ready_first", 32'(s_ready), 32'd1);

    // Single beat latency.
    next_cyc();
    s_valid = 1'b1;
    s_data  = 8'h0A;
    m_ready = 1'b1;
    #2;
    check("t2_s_ready", 32'(s_ready), 32'd1);
    next_cyc();
    s_valid = 1'b0;
    first = -1;
    for (int c = 1; c <= 8; c++) begin
      if (c == 1) check("t2_count_one", 32'(count), 32'd1);
      if (m_valid && first < 0) begin
        first = c;
        check("t2_m_data", 32'(m_data), 32'h0A);
      end
      next_cyc();
    end
    check("t2_latency", 32'(first), 32'(LAT));
    check("t2_count_zero", 32'(count), 32'd0);
    check("t2_empty", 32'(empty), 32'd1);

    // Fill to full with the reader stalled.
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      push(DW'(i), ok);
      if (i == 26) check("t3_af_at_27", 32'(almost_full), 32'd0);
      if (i == 27) check("t3_af_at_28", 32'(almost_full), 32'd1);
    end
    s_data = 8'h55;
    #1;
    check("t3_full", 32'(full), 32'd1);
    check("t3_count", 32'(count), 32'd32);
    check("t3_s_ready", 32'(s_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      check("t3_33rd_ready", 32'(s_ready), 32'd0);
      next_cyc();
    end
    check("t3_33rd_count", 32'(count), 32'd32);
    s_valid = 1'b0;

    // Drain in order.
    m_ready = 1'b1;
    got = 0;
    for (int t = 0; t < 200 && got < DEPTH; t++) begin
      #2;
      if (m_valid) begin
        check("t4_drain_data", 32'(m_data), 32'(got));
        got++;
      end
      next_cyc();
    end
    if (got != DEPTH) timeout("t4_drain");
    check("t4_empty", 32'(empty), 32'd1);
    check("t4_count", 32'(count), 32'd0);
    for (int c = 0; c < 5; c++) begin
      check("t4_no_extra_valid", 32'(m_valid), 32'd0);
      next_cyc();
    end

    // Both sides streaming.
    nxt     = 0;
    acc_win = 0;
    d0      = dlv_cnt;
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      s_data = DW'(nxt);
      #2;
      if (s_ready) begin
        nxt++;
        if (c >= 20) acc_win++;
      end
      next_cyc();
    end
    s_valid = 1'b0;
    for (int t = 0; t < 60 && mcnt != 0; t++) next_cyc();
    if (mcnt != 0) timeout("t5_drain");
    check("t5_delivered_ge_99", 32'((dlv_cnt - d0) >= 99), 32'd1);
`ifdef SPRAM_FIFO_BYPASS_EN
    check("t5_rate", 32'(acc_win >= 170), 32'd1);
`else
    check("t5_rate_half", 32'(acc_win >= 88 && acc_win <= 92), 32'd1);
`endif

    // Random backpressure.
    for (int c = 0; c < 2000; c++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = DW'($urandom);
      if (c < 1000) m_ready = ($urandom_range(0, 3) == 0);
      else          m_ready = ($urandom_range(0, 3) != 0);
      next_cyc();
    end
    s_valid = 1'b1;
    m_ready = 1'b0;
    repeat (6) next_cyc();
    #2;
    check("t6_pre_reset_count", 32'(count), 32'(mcnt));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    check("t6_s_ready", 32'(s_ready), 32'd1);
    exp_q.delete();
    mcnt = 0;
    s_valid = 1'b0;
    repeat (2) next_cyc();
    rst_n = 1'b1;
    m_ready = 1'b1;
    push(8'h3C, ok);
    s_valid = 1'b0;
    got = 0;
    for (int t = 0; t < 20 && got == 0; t++) begin
      #2;
      if (m_valid) begin
        check("t6_post_reset_data", 32'(m_data), 32'h3C);
        got++;
      end
      next_cyc();
    end
    if (got == 0) timeout("t6_post_reset");
    repeat (3) next_cyc();
    check("t6_final_empty", 32'(empty), 32'd1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
